// File: rtl/nn_sched_pkg.sv
// Shared types and helpers for the neuron scheduler: job/result structs, FSM states, lane math.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package nn_sched_pkg;

  localparam int LANES      = 8;
  localparam int LANES_LOG2 = $clog2(LANES);

  localparam logic signed [23:0] RES_MAX = 24'sh7FFFFF;
  localparam logic signed [23:0] RES_MIN = 24'sh800000;

  typedef struct packed {
    logic [9:0]  ninputs;
    logic [10:0] neuron;
    logic [16:0] tbl;
    logic [16:0] oloc;
    logic [4:0]  postshift;
    logic [4:0]  neuronshift;
  } job_t;

  typedef struct packed {
    logic [23:0] data;
    logic [16:0] oloc;
    logic [10:0] neuron;
    logic [4:0]  neuronshift;
  } res_t;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SHIFT, OUTPUT} state_t;

  // ceil(ninputs / LANES); 1023 inputs still fits in 8 bits (128 chunks)
  function automatic logic [7:0] nchunks_of(input logic [9:0] nin);
    return 8'((11'(nin) + 11'(LANES - 1)) >> LANES_LOG2);
  endfunction

  // Full mask except a partial final chunk, which keeps only the remainder lanes
  function automatic logic [LANES-1:0] lane_mask(input logic [9:0] nin, input logic [7:0] idx);
    logic [LANES_LOG2-1:0] rem;
    logic [LANES-1:0]      m;
    rem = nin[LANES_LOG2-1:0];
    m   = '1;
    if ((idx == nchunks_of(nin) - 8'd1) && (rem != '0)) begin
      m = (LANES'(1) << rem) - LANES'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/nn_neuron_scheduler_if.sv
// Bundles the job, chunk, sum and result handshakes between the scheduler and its neighbours.
// Latency: none (wiring only).
// Backpressure: job_stop, chunk_stop and res_stop stall their respective push signals.
interface nn_neuron_scheduler_if;
  logic        job_push;
  logic        job_stop;
  logic [9:0]  job_ninputs;
  logic [10:0] job_neuron;
  logic [16:0] job_table;
  logic [16:0] job_oloc;
  logic [4:0]  job_postshift;
  logic [4:0]  job_neuronshift;

  logic        chunk_push;
  logic        chunk_stop;
  logic [16:0] chunk_waddr;
  logic [7:0]  chunk_lanes;
  logic        chunk_last;

  logic        sum_push;
  logic [47:0] sum_data;

  logic        res_push;
  logic        res_stop;
  logic [23:0] res_data;
  logic [16:0] res_oloc;
  logic [10:0] res_neuron;
  logic [4:0]  res_neuronshift;

  logic        busy;

  // Scheduler side
  modport master (
    input  job_push, job_ninputs, job_neuron, job_table, job_oloc, job_postshift, job_neuronshift,
    output job_stop,
    output chunk_push, chunk_waddr, chunk_lanes, chunk_last,
    input  chunk_stop,
    input  sum_push, sum_data,
    output res_push, res_data, res_oloc, res_neuron, res_neuronshift,
    input  res_stop,
    output busy
  );

  // Job source, calc datapath and writeback side
  modport slave (
    output job_push, job_ninputs, job_neuron, job_table, job_oloc, job_postshift, job_neuronshift,
    input  job_stop,
    input  chunk_push, chunk_waddr, chunk_lanes, chunk_last,
    output chunk_stop,
    output sum_push, sum_data,
    input  res_push, res_data, res_oloc, res_neuron, res_neuronshift,
    output res_stop,
    input  busy
  );
endinterface

// File: rtl/nn_sat_shift.sv
// Arithmetic right shift of the accumulator, saturation to 24-bit signed, optional ReLU (NN_SCHED_RELU_EN).
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module nn_sat_shift
  import nn_sched_pkg::*;
#(
  parameter int ACC_W = 56
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [4:0]              shift,
  output logic [23:0]             res
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] max_ext;
  logic signed [ACC_W-1:0] min_ext;

  assign shifted = acc >>> shift;
  assign max_ext = $signed({{(ACC_W-24){RES_MAX[23]}}, RES_MAX});
  assign min_ext = $signed({{(ACC_W-24){RES_MIN[23]}}, RES_MIN});

  // Clamp to the 24-bit signed range, then optionally drop negatives
  always_comb begin
    res = shifted[23:0];
    if (shifted > max_ext) begin
      res = RES_MAX;
    end else if (shifted < min_ext) begin
      res = RES_MIN;
    end
`ifdef NN_SCHED_RELU_EN
    if (res[23]) begin
      res = '0;
    end
`endif
  end

endmodule

// File: rtl/nn_neuron_scheduler.sv
// Splits one neuron job into LANES-wide calc chunks, accumulates returned sums, emits a shifted/saturated result.
// Latency: first chunk request the cycle after accept; result 2 cycles after the last sum (ReLU via NN_SCHED_RELU_EN).
// Backpressure: job_stop outside IDLE; chunk request held under chunk_stop; result held under res_stop.
module nn_neuron_scheduler
  import nn_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ACC_W           = 56
) (
  input  logic                  clk,
  input  logic                  reset,
  nn_neuron_scheduler_if.master bus
);

  state_t                  state;
  job_t                    job_q;
  job_t                    job_in;
  res_t                    res_q;
  logic [7:0]              nchunks;
  logic [7:0]              issued;
  logic [7:0]              returned;
  logic signed [ACC_W-1:0] acc;
  logic                    chunk_push_q;
  logic [16:0]             chunk_waddr_q;
  logic [7:0]              chunk_lanes_q;
  logic                    chunk_last_q;
  logic                    res_push_q;
  logic                    job_stop_q;
  logic                    busy_q;

  logic                    xfer;
  logic                    ret;
  logic [7:0]              issued_nx;
  logic [7:0]              returned_nx;
  logic [7:0]              out_nx;
  logic [7:0]              in_nchunks;
  logic signed [ACC_W-1:0] sum_ext;
  logic [23:0]             sat_res;

  assign job_in = '{ninputs: bus.job_ninputs, neuron: bus.job_neuron, tbl: bus.job_table,
                    oloc: bus.job_oloc, postshift: bus.job_postshift,
                    neuronshift: bus.job_neuronshift};

  // Counter look-ahead: registered chunk outputs are computed from post-edge counts
  assign xfer        = chunk_push_q && !bus.chunk_stop;
  assign ret         = bus.sum_push && ((state == ISSUE) || (state == DRAIN));
  assign issued_nx   = issued + {7'd0, xfer};
  assign returned_nx = returned + {7'd0, ret};
  assign out_nx      = issued_nx - returned_nx;
  assign in_nchunks  = nchunks_of(bus.job_ninputs);
  assign sum_ext     = $signed({{(ACC_W-48){bus.sum_data[47]}}, bus.sum_data});

  nn_sat_shift #(.ACC_W(ACC_W)) u_sat_shift (
    .acc   (acc),
    .shift (job_q.postshift),
    .res   (sat_res)
  );

  // Job FSM: issue chunks, collect sums, shift/saturate, present result
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      job_q         <= '0;
      res_q         <= '0;
      nchunks       <= '0;
      issued        <= '0;
      returned      <= '0;
      acc           <= '0;
      chunk_push_q  <= 1'b0;
      chunk_waddr_q <= '0;
      chunk_lanes_q <= '0;
      chunk_last_q  <= 1'b0;
      res_push_q    <= 1'b0;
      job_stop_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          job_stop_q <= 1'b0;
          if (bus.job_push && !job_stop_q) begin
            job_q      <= job_in;
            nchunks    <= in_nchunks;
            issued     <= '0;
            returned   <= '0;
            acc        <= '0;
            job_stop_q <= 1'b1;
            busy_q     <= 1'b1;
            if (job_in.ninputs == '0) begin
              state <= SHIFT;
            end else begin
              state         <= ISSUE;
              chunk_push_q  <= 1'b1;
              chunk_waddr_q <= job_in.tbl;
              chunk_lanes_q <= lane_mask(job_in.ninputs, 8'd0);
              chunk_last_q  <= (in_nchunks == 8'd1);
            end
          end
        end
        ISSUE: begin
          issued        <= issued_nx;
          returned      <= returned_nx;
          if (ret) acc  <= acc + sum_ext;
          chunk_push_q  <= (issued_nx < nchunks) && (out_nx < 8'(MAX_OUTSTANDING));
          chunk_waddr_q <= job_q.tbl + (17'(issued_nx) << LANES_LOG2);
          chunk_lanes_q <= lane_mask(job_q.ninputs, issued_nx);
          chunk_last_q  <= (issued_nx == nchunks - 8'd1);
          if (issued_nx == nchunks) state <= DRAIN;
        end
        DRAIN: begin
          returned     <= returned_nx;
          if (ret) acc <= acc + sum_ext;
          if (returned_nx == nchunks) state <= SHIFT;
        end
        SHIFT: begin
          res_q      <= '{data: sat_res, oloc: job_q.oloc, neuron: job_q.neuron,
                          neuronshift: job_q.neuronshift};
          res_push_q <= 1'b1;
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (!bus.res_stop) begin
            res_push_q <= 1'b0;
            busy_q     <= 1'b0;
            job_stop_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.job_stop        = job_stop_q;
  assign bus.busy            = busy_q;
  assign bus.chunk_push      = chunk_push_q;
  assign bus.chunk_waddr     = chunk_waddr_q;
  assign bus.chunk_lanes     = chunk_lanes_q;
  assign bus.chunk_last      = chunk_last_q;
  assign bus.res_push        = res_push_q;
  assign bus.res_data        = res_q.data;
  assign bus.res_oloc        = res_q.oloc;
  assign bus.res_neuron      = res_q.neuron;
  assign bus.res_neuronshift = res_q.neuronshift;

endmodule

// File: doc/nn_neuron_scheduler.md
Name: nn_neuron_scheduler

Overview:
Sequences the 8-lane MAC/adder-tree calc datapath for one neuron at a time. It accepts a neuron job descriptor, splits the job's Ninputs into 8-wide chunks and issues them to calc under a push/stop handshake. It accumulates the 48-bit chunk sums calc returns, then applies PostShift with saturation and emits one 24-bit result per neuron toward the writeback/activation stage.

Parameters:
- LANES, 8, MAC lanes per calc chunk; must be a power of 2.
- MAX_OUTSTANDING, 4, maximum chunks issued to calc whose sums have not yet returned.
- ACC_W, 56, signed accumulator width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- job_push  in  1  job descriptor valid.
- job_stop  out  1  scheduler cannot accept a job.
- job_ninputs  in  10  number of inputs for the neuron, 0..1023.
- job_neuron  in  11  neuron number.
- job_table  in  17  NeuronTable base (weight base address).
- job_oloc  in  17  output location.
- job_postshift  in  5  arithmetic right shift applied to the final sum.
- job_neuronshift  in  5  passed through unchanged.
- chunk_push  out  1  chunk request valid to calc.
- chunk_stop  in  1  calc busy; hold the request.
- chunk_waddr  out  17  job_table + chunk_idx*LANES.
- chunk_lanes  out  8  active-lane mask.
- chunk_last  out  1  final chunk of the neuron.
- sum_push  in  1  calc returns one chunk sum.
- sum_data  in  48  signed chunk sum.
- res_push  out  1  result valid.
- res_stop  in  1  downstream backpressure.
- res_data  out  24  saturated, shifted result.
- res_oloc  out  17  output location.
- res_neuron  out  11  neuron number.
- res_neuronshift  out  5  pass-through.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, except job_stop, which is 1 during reset and 0 in IDLE after reset.
  - Counters and accumulator clear.
  - In-flight chunks are abandoned. A sum_push during or after reset while in IDLE is ignored.
- Chunk count: nchunks = ceil(ninputs/LANES).
  - Lane mask is all ones, except on the last chunk, where it is ((1<<(ninputs%LANES))-1) when the remainder is nonzero.
- States:
  - IDLE: job_stop=0. On job_push, latch the descriptor, clear acc, issued and returned counters, then go to ISSUE. If ninputs==0, go straight to SHIFT with acc=0.
  - ISSUE:
    - chunk_push=1 while issued<nchunks and outstanding<MAX_OUTSTANDING.
    - A transfer happens on a cycle with chunk_push&&!chunk_stop. On transfer, issued++.
    - chunk_waddr, chunk_lanes and chunk_last are stable while stopped.
    - When issued==nchunks, go to DRAIN.
  - DRAIN: wait until returned==nchunks, then go to SHIFT.
  - SHIFT: one cycle. shifted = acc >>> postshift (arithmetic). Saturate to [-2^23, 2^23-1] and register. Go to OUTPUT.
  - OUTPUT: res_push=1. Hold all res_* while res_stop. On !res_stop, go to IDLE.
- Sum return:
  - In ISSUE or DRAIN, sum_push adds sign-extended sum_data into acc and increments returned.
  - A simultaneous issue and return in one cycle updates both counters; outstanding is unchanged.
  - sum_push in IDLE, SHIFT or OUTPUT is dropped.
- job_stop=1 in every state but IDLE. Only one job is in flight at a time.
- Latency with no stalls:
  - The job accept cycle is followed by the first chunk_push.
  - The result appears 2 cycles after the last sum return.
- The accumulator never wraps, because ACC_W covers 128 chunks of 48 bits.

Optional Feature:
- NN_SCHED_RELU_EN:
  - Defined: a negative saturated result is replaced by 0 in SHIFT.
  - Undefined: signed results pass unchanged.
  - Latency is identical either way.

Decomposition:
- Package nn_sched_pkg holds:
  - the job descriptor struct (ninputs, neuron, table, oloc, postshift, neuronshift);
  - the result struct;
  - the state enum (IDLE, ISSUE, DRAIN, SHIFT, OUTPUT);
  - LANES and the RES_MAX/RES_MIN constants.
- One sub-module, nn_sat_shift, is combinational: shift, saturate and optional ReLU.

Test Plan:
- Job ninputs=20, table=0x100, postshift=0, calc sums 5, 7, -2 -> waddr 0x100/0x108/0x110, lanes FF/FF/0F, chunk_last on the third chunk, res_data=10.
- Job ninputs=0, oloc=0x55 -> no chunk_push; res_push with res_data=0 and res_oloc=0x55 two cycles after accept.
- ninputs=64, sums withheld -> exactly 4 chunk_push transfers, then stall until a sum returns; the fifth issues on the cycle after the first sum_push.
- Sums totaling 2^30, postshift=4 -> res_data=0x7FFFFF (saturated). Sum -2^30 -> 0x800000, or 0 with NN_SCHED_RELU_EN.
- chunk_stop high for 3 cycles, and res_stop high for 2 cycles -> request and result fields held stable, no duplicate transfer.
- reset=0 mid-DRAIN with 2 sums pending -> all outputs 0. Late sum_push ignored. The next job produces the correct result.
